// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: opcodes, sequencer
// states (their encoding is also the LED stage value) and flag bit positions.
package calc_pkg;

    // Default operand/result width of the calculator core.
    localparam int CALC_W = 16;

    // Width of the core's exception flag vector.
    localparam int FLAG_W = 6;

    // Opcode values as entered on switches[1:0].
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Bit positions inside calc_flags / result_flags.
    localparam int FLAG_INVALID   = 5;
    localparam int FLAG_EXCEPTION = 4;
    localparam int FLAG_INEXACT   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_SIGN      = 0;

    // Sequencer states; the numeric value is shown on the stage LEDs.
    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_OP    = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter that
// only accepts a level change after DEBOUNCE_CYCLES consecutive differing
// samples, and a one-cycle pulse on the accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the raw button into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has been stable long enough; the
    // press pulse is registered together with the accepted rising edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/calc_operand_sequencer.sv
// Board front end for the calculator core: collects A, B and opcode over
// three button presses, issues one start pulse, waits (bounded) for the
// core's ready and holds the outcome on the LEDs until acknowledged.
module calc_operand_sequencer
    import calc_pkg::*;
#(
    parameter int W               = CALC_W,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_enter,
    input  logic [W-1:0]      switches,
    output logic [W-1:0]      op_a,
    output logic [W-1:0]      op_b,
    output logic [1:0]        opcode,
    output logic              start,
    input  logic              calc_ready,
    input  logic [W-1:0]      calc_result,
    input  logic [FLAG_W-1:0] calc_flags,
    output logic [W-1:0]      result,
    output logic [FLAG_W-1:0] result_flags,
    output logic              done,
    output logic              timeout,
    output logic              bad_op,
    output logic [2:0]        stage
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [W-1:0]      r_op_a;
    logic [W-1:0]      r_op_b;
    logic [1:0]        r_opcode;
    logic              r_start;
    logic [W-1:0]      r_result;
    logic [FLAG_W-1:0] r_result_flags;
    logic              r_done;
    logic              r_timeout;
    logic              r_bad_op;
    logic [TMR_W-1:0]  r_timer;

    logic              w_press;
    logic              w_op_in_range;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_debounce (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_btn   (btn_enter),
        .o_press (w_press)
    );

    // Only the four defined opcodes may be entered; any high switch is an error.
    assign w_op_in_range = (switches[W-1:2] == '0);

    // Operation sequencer; every output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_A;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_opcode       <= OP_ADD;
            r_start        <= 1'b0;
            r_result       <= '0;
            r_result_flags <= '0;
            r_done         <= 1'b0;
            r_timeout      <= 1'b0;
            r_bad_op       <= 1'b0;
            r_timer        <= '0;
        end else begin
            // start is raised only on entry to S_ISSUE, so it lasts one cycle.
            r_start <= 1'b0;
            case (r_state)
                S_A: begin
                    if (w_press) begin
                        r_op_a  <= switches;
                        r_state <= S_B;
                    end
                end
                S_B: begin
                    if (w_press) begin
                        r_op_b  <= switches;
                        r_state <= S_OP;
                    end
                end
                S_OP: begin
                    if (w_press) begin
                        if (w_op_in_range) begin
                            r_opcode <= switches[1:0];
                            r_start  <= 1'b1;
                            r_state  <= S_ISSUE;
                        end else begin
                            r_bad_op <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    // A ready seen while start is still on the wire is stale.
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // Ready has priority over expiry in the same cycle.
                    if (calc_ready) begin
                        r_result       <= calc_result;
                        r_result_flags <= calc_flags;
                        r_done         <= 1'b1;
                        r_state        <= S_DONE;
                    end else if (r_timer == TMR_LAST) begin
                        r_timeout <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result and operands stay visible; only status clears.
                    if (w_press) begin
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_bad_op  <= 1'b0;
                        r_state   <= S_A;
                    end
                end
                default: begin
                    r_state <= S_A;
                end
            endcase
        end
    end

    assign op_a         = r_op_a;
    assign op_b         = r_op_b;
    assign opcode       = r_opcode;
    assign start        = r_start;
    assign result       = r_result;
    assign result_flags = r_result_flags;
    assign done         = r_done;
    assign timeout      = r_timeout;
    assign bad_op       = r_bad_op;
    assign stage        = r_state;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Self-checking bench for calc_operand_sequencer: a behavioural core model
// answers start pulses with a chosen delay, and an abstract model of the
// expected board outputs is updated per user action.
module tb_calc_operand_sequencer;

    localparam int W     = 16;
    localparam int DEB   = 4;
    localparam int TO    = 16;
    localparam int NEVER = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_enter;
    logic [W-1:0]  switches;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [1:0]    opcode;
    logic          start;
    logic          calc_ready;
    logic [W-1:0]  calc_result;
    logic [5:0]    calc_flags;
    logic [W-1:0]  result;
    logic [5:0]    result_flags;
    logic          done;
    logic          timeout;
    logic          bad_op;
    logic [2:0]    stage;

    calc_operand_sequencer #(
        .W               (W),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_enter    (btn_enter),
        .switches     (switches),
        .op_a         (op_a),
        .op_b         (op_b),
        .opcode       (opcode),
        .start        (start),
        .calc_ready   (calc_ready),
        .calc_result  (calc_result),
        .calc_flags   (calc_flags),
        .result       (result),
        .result_flags (result_flags),
        .done         (done),
        .timeout      (timeout),
        .bad_op       (bad_op),
        .stage        (stage)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // expected board-visible state
    logic [W-1:0] m_op_a, m_op_b, m_result;
    logic [1:0]   m_opcode;
    logic [5:0]   m_flags;
    logic         m_done, m_timeout, m_bad;
    logic [2:0]   m_stage;

    // core model controls and observations
    int         core_delay = NEVER;
    bit         core_early = 1'b0;
    logic [W-1:0] core_res = '0;
    logic [5:0] core_flg = '0;
    bit         core_busy = 1'b0;
    int         n_starts = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    logic       prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: answers in wait cycle core_delay after the start cycle.
    always begin
        @(negedge clk);
        if (start === 1'b1) begin
            core_busy = 1'b1;
            start_cyc = cyc;
            if (core_early) begin
                calc_ready  = 1'b1;
                calc_result = ~core_res;
                calc_flags  = ~core_flg;
            end
            for (int k = 0; k <= core_delay; k++) begin
                @(negedge clk);
                calc_ready = 1'b0;
            end
            if (core_delay < NEVER) begin
                calc_ready  = 1'b1;
                calc_result = core_res;
                calc_flags  = core_flg;
                @(negedge clk);
                calc_ready  = 1'b0;
            end
            core_busy = 1'b0;
        end
    end

    // Count start cycles and time the rise of done.
    always @(negedge clk) begin
        if (start === 1'b1) n_starts = n_starts + 1;
        if (done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = done;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".op_a"},    32'(op_a),         32'(m_op_a));
        chk({tag, ".op_b"},    32'(op_b),         32'(m_op_b));
        chk({tag, ".opcode"},  32'(opcode),       32'(m_opcode));
        chk({tag, ".start"},   32'(start),        32'(0));
        chk({tag, ".result"},  32'(result),       32'(m_result));
        chk({tag, ".flags"},   32'(result_flags), 32'(m_flags));
        chk({tag, ".done"},    32'(done),         32'(m_done));
        chk({tag, ".timeout"}, 32'(timeout),      32'(m_timeout));
        chk({tag, ".bad_op"},  32'(bad_op),       32'(m_bad));
        chk({tag, ".stage"},   32'(stage),        32'(m_stage));
    endtask

    task automatic model_clear();
        m_op_a = '0; m_op_b = '0; m_result = '0; m_opcode = '0; m_flags = '0;
        m_done = 1'b0; m_timeout = 1'b0; m_bad = 1'b0; m_stage = 3'd0;
    endtask

    // One clean press and release, leaving plenty of settling time.
    task automatic press(input logic [W-1:0] sw);
        switches  = sw;
        btn_enter = 1'b1;
        repeat (DEB + 8) @(negedge clk);
        btn_enter = 1'b0;
        repeat (DEB + 6) @(negedge clk);
    endtask

    task automatic wait_core(input int lim);
        int n = 0;
        while (core_busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("core_idle", 32'(core_busy), 32'(0));
    endtask

    task automatic enter_a(input logic [W-1:0] sw);
        press(sw);
        m_op_a = sw; m_stage = 3'd1;
        check_all("A");
    endtask

    task automatic enter_b(input logic [W-1:0] sw);
        press(sw);
        m_op_b = sw; m_stage = 3'd2;
        check_all("B");
    endtask

    // Operand A entered through a bouncing contact.
    task automatic bounce_a(input logic [W-1:0] sw);
        switches = sw;
        for (int i = 0; i < 10; i++) begin
            btn_enter = ~i[0];
            repeat (2) @(negedge clk);
        end
        btn_enter = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);
        m_op_a = sw; m_stage = 3'd1;
        check_all("bounceA");
    endtask

    task automatic op_phase(input logic [W-1:0] opw, input int d, input bit early,
                            input logic [W-1:0] res, input logic [5:0] flg);
        int s0;
        s0 = n_starts;
        core_delay = d; core_early = early; core_res = res; core_flg = flg;
        press(opw);
        wait_core(80);
        repeat (2) @(negedge clk);
        m_done = 1'b1; m_stage = 3'd5;
        if (opw[W-1:2] != 0) begin
            m_bad = 1'b1;
            chk("starts_badop", 32'(n_starts - s0), 32'(0));
        end else begin
            m_opcode = opw[1:0];
            if (d <= TO - 1) begin
                m_result = res; m_flags = flg;
                chk("lat_ready", 32'(done_cyc - start_cyc), 32'(d + 2));
            end else begin
                m_timeout = 1'b1;
                chk("lat_timeout", 32'(done_cyc - start_cyc), 32'(TO + 1));
            end
            chk("starts", 32'(n_starts - s0), 32'(1));
        end
        check_all("op");
    endtask

    task automatic ack();
        press(16'($urandom));
        m_done = 1'b0; m_timeout = 1'b0; m_bad = 1'b0; m_stage = 3'd0;
        check_all("ack");
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] opw,
                           input int d, input bit early, input logic [W-1:0] res, input logic [5:0] flg);
        enter_a(a);
        enter_b(b);
        op_phase(opw, d, early, res, flg);
        ack();
    endtask

    // Reset pulled during S_WAIT; the core answers after reset is released.
    task automatic reset_mid_wait();
        int s0;
        int n;
        enter_a(16'($urandom));
        enter_b(16'($urandom));
        s0 = n_starts;
        core_delay = 10; core_early = 1'b0;
        core_res = 16'hBEEF; core_flg = 6'h2A;
        switches  = 16'h0002;
        btn_enter = 1'b1;
        n = 0;
        while (start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rst_start_seen", 32'(start), 32'(1));
        btn_enter = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        model_clear();
        check_all("rst_async");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_core(80);
        repeat (3) @(negedge clk);
        check_all("rst_after");
        chk("rst_starts", 32'(n_starts - s0), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] opw;
        int d;
        rst = 1'b0; btn_enter = 1'b0; switches = '0;
        calc_ready = 1'b0; calc_result = '0; calc_flags = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all("post_reset");

        // Directed add: 1.0 + 2.0 in half precision.
        full_op(16'h3C00, 16'h4000, 16'h0000, 2, 1'b0, 16'h4200, 6'h00);

        // Bounce on A, then ready exactly at the last timer cycle.
        bounce_a(16'($urandom));
        enter_b(16'($urandom));
        op_phase(16'h0001, TO - 1, 1'b0, 16'($urandom), 6'($urandom));
        ack();

        // Out-of-range opcode.
        full_op(16'($urandom), 16'($urandom), 16'h0005, 2, 1'b0, 16'h1111, 6'h3F);

        // Timeout, then a late ready that must not be captured.
        full_op(16'($urandom), 16'($urandom), 16'h0003, TO + 4, 1'b0, 16'h7777, 6'h15);

        // Ready one cycle after expiry.
        full_op(16'($urandom), 16'($urandom), 16'h0002, TO, 1'b0, 16'h5A5A, 6'h01);

        // Early ready during S_ISSUE, then a real answer; then early only.
        full_op(16'($urandom), 16'($urandom), 16'h0001, 5, 1'b1, 16'hC0DE, 6'h21);
        full_op(16'($urandom), 16'($urandom), 16'h0000, NEVER, 1'b1, 16'h0F0F, 6'h0C);

        // Randomised operations.
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                opw = 16'($urandom_range(0, 3));
            end else begin
                opw = 16'($urandom);
                if (opw[W-1:2] == 0) opw[W-1] = 1'b1;
            end
            d = $urandom_range(0, TO + 6);
            if ($urandom_range(0, 4) == 0) d = NEVER;
            full_op(16'($urandom), 16'($urandom), opw, d, 1'($urandom_range(0, 1)),
                    16'($urandom), 6'($urandom));
        end

        // Reset during the wait, then a normal operation afterwards.
        reset_mid_wait();
        full_op(16'h1234, 16'h5678, 16'h0003, 4, 1'b0, 16'h9ABC, 6'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
